// File: rtl/alu_operand_regfile.sv
// 32x32 register file with ALU operand select; combinational reads, clocked writes.
// r0 is hardwired to zero and reads never bypass the write port, since d feeds back from a/b.
module alu_operand_regfile #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rna,
    input  logic [4:0]       rnb,
    input  logic [4:0]       wn,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    input  logic [4:0]       sa,
    input  logic [15:0]      imm,
    input  logic             shift,
    input  logic             lui,
    input  logic             aluimm,
    input  logic             sext,
    input  logic [4:0]       dbg_rn,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] dbg_q
);

    logic [WIDTH-1:0] regs [NREG-1:1];
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] imm_z;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] sa_z;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (we && wn != 5'd0) begin
            regs[wn] <= d;
        end
    end

    // Address 0 has no storage behind it.
    assign qa    = (rna    == 5'd0) ? '0 : regs[rna];
    assign qb    = (rnb    == 5'd0) ? '0 : regs[rnb];
    assign dbg_q = (dbg_rn == 5'd0) ? '0 : regs[dbg_rn];

    assign imm_z = {{(WIDTH-16){1'b0}}, imm};
    assign imm_s = {{(WIDTH-16){imm[15]}}, imm};
    assign sa_z  = {{(WIDTH-5){1'b0}}, sa};

    // lui outranks shift; the pair is illegal but must still resolve deterministically.
    always_comb begin
        a = qa;
        if (lui)        a = imm_z;
        else if (shift) a = sa_z;
    end

    always_comb begin
        b = qb;
        if (aluimm) b = sext ? imm_s : imm_z;
    end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Scoreboarded bench for alu_operand_regfile: directed cases plus a random run against a register model.
module tb_alu_operand_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rna, rnb, wn, sa, dbg_rn;
    logic        we, shift, lui, aluimm, sext;
    logic [31:0] d;
    logic [15:0] imm;
    logic [31:0] a, b, qb, dbg_q;

    alu_operand_regfile #(.WIDTH(32), .NREG(32)) dut (
        .clock(clock), .reset(reset), .rna(rna), .rnb(rnb), .wn(wn), .we(we), .d(d),
        .sa(sa), .imm(imm), .shift(shift), .lui(lui), .aluimm(aluimm), .sext(sext),
        .dbg_rn(dbg_rn), .a(a), .b(b), .qb(qb), .dbg_q(dbg_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) assert (!(lui && shift)) else $error("lui and shift both set");

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] m [32];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sbq.push_back(e);
    endtask

    // Let combinational outputs settle, then retire every queued expectation.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                0:       obs = a;
                1:       obs = b;
                2:       obs = qb;
                default: obs = dbg_q;
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] val);
        we = 1'b1; wn = addr; d = val;
        tick();
        we = 1'b0;
        if (addr != 5'd0) m[addr] = val;
    endtask

    initial begin
        logic [31:0] ea, eb;
        int          mode;
        for (int i = 0; i < 32; i++) m[i] = '0;
        reset = 1'b1; we = 1'b0; wn = '0; d = '0; sa = '0; imm = '0;
        shift = 1'b0; lui = 1'b0; aluimm = 1'b0; sext = 1'b0;
        rna = 5'd5; rnb = 5'd5; dbg_rn = 5'd5;
        #1;
        push("rst_a", 0, 32'h0); push("rst_b", 1, 32'h0);
        push("rst_qb", 2, 32'h0); push("rst_dbg", 3, 32'h0);
        drain();
        @(negedge clock);
        reset = 1'b0;
        tick();
        push("post_rst_a", 0, 32'h0); push("post_rst_dbg", 3, 32'h0);
        drain();

        // Same-cycle read sees the old value; new value after the edge.
        rna = 5'd3; we = 1'b1; wn = 5'd3; d = 32'hDEADBEEF;
        push("wr_old_a", 0, 32'h0);
        drain();
        tick();
        we = 1'b0; m[3] = 32'hDEADBEEF;
        push("wr_new_a", 0, 32'hDEADBEEF);
        drain();

        rnb = 5'd3; dbg_rn = 5'd3;
        push("same_a", 0, 32'hDEADBEEF); push("same_qb", 2, 32'hDEADBEEF);
        push("same_dbg", 3, 32'hDEADBEEF); push("same_b", 1, 32'hDEADBEEF);
        drain();

        wr(5'd0, 32'h12345678);
        rna = 5'd0; rnb = 5'd0; dbg_rn = 5'd0;
        push("r0_a", 0, 32'h0); push("r0_qb", 2, 32'h0); push("r0_dbg", 3, 32'h0);
        drain();

        imm = 16'h8001; aluimm = 1'b1; sext = 1'b1;
        push("sext_b", 1, 32'hFFFF8001);
        drain();
        sext = 1'b0;
        push("zext_b", 1, 32'h00008001);
        drain();
        aluimm = 1'b0; rnb = 5'd3;
        push("b_reg", 1, 32'hDEADBEEF);
        drain();

        wr(5'd7, 32'hFFFFFFFF);
        rna = 5'd7;
        push("a_reg7", 0, 32'hFFFFFFFF);
        drain();
        shift = 1'b1; sa = 5'd31;
        push("shift_a", 0, 32'h0000001F);
        drain();
        shift = 1'b0; lui = 1'b1; imm = 16'hABCD;
        push("lui_a", 0, 32'h0000ABCD);
        drain();
        chk("lui_alu", a << 16, 32'hABCD0000);
        lui = 1'b0;

        // Async reset between edges clears storage without a clock.
        wr(5'd9, 32'h55AA55AA);
        dbg_rn = 5'd9;
        push("r9_dbg", 3, 32'h55AA55AA);
        drain();
        reset = 1'b1;
        push("async_dbg", 3, 32'h0);
        drain();
        for (int i = 0; i < 32; i++) m[i] = '0;
        we = 1'b1; wn = 5'd9; d = 32'h11111111;
        tick();
        we = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        push("rst_wr_lost", 3, 32'h0);
        drain();
        wr(5'd9, 32'h22222222);
        push("first_wr", 3, 32'h22222222);
        drain();

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            rna = 5'($urandom); rnb = 5'($urandom); dbg_rn = 5'($urandom);
            wn = 5'($urandom_range(0, 7)); we = 1'($urandom); d = $urandom;
            sa = 5'($urandom); imm = 16'($urandom);
            mode = $urandom_range(0, 2);
            lui = (mode == 1); shift = (mode == 2);
            aluimm = 1'($urandom); sext = 1'($urandom);
            ea = lui ? {16'h0, imm} : shift ? {27'h0, sa} : m[rna];
            eb = !aluimm ? m[rnb] : sext ? {{16{imm[15]}}, imm} : {16'h0, imm};
            push("rnd_a", 0, ea); push("rnd_b", 1, eb);
            push("rnd_qb", 2, m[rnb]); push("rnd_dbg", 3, m[dbg_rn]);
            drain();
            tick();
            if (we && wn != 5'd0) m[wn] = d;
            we = 1'b0;
            push("rnd_qb_post", 2, m[rnb]); push("rnd_dbg_post", 3, m[dbg_rn]);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- 32x32-bit register file plus operand-select logic, directly upstream of the single-cycle CPU's ALU; drives its a and b inputs.
- Reads are combinational and writes are clocked, so one instruction completes per cycle.
- Also provides the raw rt value for stores and a debug read port for FPGA LED / seven-segment display.

Parameters:
- WIDTH, 32, data width of registers and operands.
- NREG, 32, number of registers. Address width is fixed at 5; NREG must be 32.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset; clears all registers
- rna  in  5  rs read address
- rnb  in  5  rt read address
- wn  in  5  write address
- we  in  1  write enable
- d  in  WIDTH  write data (from ALU result or memory mux)
- sa  in  5  shift amount field
- imm  in  16  immediate field
- shift  in  1  a selects zero-extended sa (SLL/SRL/SRA)
- lui  in  1  a selects zero-extended imm (ALU performs the <<16)
- aluimm  in  1  b selects extended imm
- sext  in  1  1 = sign-extend imm for b, 0 = zero-extend
- dbg_rn  in  5  debug read address
- a  out  WIDTH  ALU operand a
- b  out  WIDTH  ALU operand b
- qb  out  WIDTH  raw register[rnb] (store data)
- dbg_q  out  WIDTH  register[dbg_rn]

Behaviour:
- Storage: regs 1..31 are flops. Register 0 is not stored; every read of address 0 returns 0.
- Write: on rising clock, if we=1 and wn!=0 and reset=0, then reg[wn] <= d. Writes to wn=0 are silently dropped.
- Reset: asynchronous. While reset=1, all registers are 0.
  - A write on an edge where reset=1 is lost.
  - First write takes effect on the first rising edge with reset=0.
- Reset asserted mid-operation: contents clear immediately (no clock needed). Outputs follow combinationally.
- Reads: qa=reg[rna], qb=reg[rnb], dbg_q=reg[dbg_rn], all combinational from stored state.
  - No write-through bypass. Same-cycle read of wn returns the old value; the new value is visible after the edge.
  - Bypassing is forbidden: d depends on a/b through the ALU, so a bypass creates a combinational loop.
- Operand a priority: lui → {16'b0, imm}; else shift → {27'b0, sa}; else qa.
  - lui and shift both 1 is illegal. lui wins; verification flags it as an assertion.
- Operand b: aluimm=1 → sext ? {{16{imm[15]}}, imm} : {16'b0, imm}; aluimm=0 → qb.
- Reset values of outputs: with all regs 0,
  - a = 0 unless lui or shift is set (then the extended field);
  - b = 0 unless aluimm is set;
  - qb = 0 and dbg_q = 0.
- Latency: write→read visibility is 1 edge. Address/select→output is combinational, 0 cycles.
- Simultaneous reads of the same address on all three ports are legal and return identical data.
- X on unused select inputs must not propagate: muxes are fully specified.

Test Plan:
- Reset then read: reset=1, rna=rnb=dbg_rn=5, selects 0 → a=b=qb=dbg_q=0. Deassert reset; still 0.
- Write/readback: we=1, wn=3, d=32'hDEADBEEF, edge → rna=3 gives a=32'hDEADBEEF. Same cycle as the write, rna=3 showed the old value 0.
- r0 protection: we=1, wn=0, d=32'h12345678, edge → rna=0 gives a=0.
- Immediate extension: imm=16'h8001, aluimm=1, sext=1 → b=32'hFFFF8001; sext=0 → b=32'h00008001.
- Shift/LUI select:
  - reg[7]=32'hFFFFFFFF, rna=7, shift=1, sa=5'd31 → a=32'h0000001F.
  - lui=1, imm=16'hABCD → a=32'h0000ABCD; ALU LUI then yields 32'hABCD0000.
- Async reset mid-run: reg[9]=32'h55AA55AA, pulse reset between edges → dbg_rn=9 gives dbg_q=0 before the next edge. A write with we=1 on an edge during reset is not stored.
